// File: rtl/adder_error_monitor.sv
// adder_error_monitor: accumulates mismatch count, summed and max error distance of exact vs approximate sums
module adder_error_monitor #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] exact_sum,
    input  logic [WIDTH-1:0] approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH-1:0] max_ed
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d, cnt_q, cnt_d, err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d, diff_q, diff_d;
    logic mis_q, mis_d, v1_q, v1_d, ready_q, ready_d, accept;
    logic [WIDTH:0] sub;
    logic [ACC_W:0] sum_ext;
    always_comb begin
        accept = in_valid & ready_q;
        sub = {1'b0, exact_sum} - {1'b0, approx_sum};
        diff_d = sub[WIDTH] ? WIDTH'(-sub) : sub[WIDTH-1:0];
        mis_d = |diff_d;
        v1_d = accept;
        sum_ext = {1'b0, sum_q} + (ACC_W+1)'(diff_q);
        state_d = state_q;
        target_d = target_q;
        cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
        err_d = v1_q ? err_q + CNT_W'(mis_q) : err_q;
        sum_d = !v1_q ? sum_q : sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        max_d = v1_q && diff_q > max_q ? diff_q : max_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                target_d = num_samples;
                cnt_d = '0;
                err_d = '0;
                sum_d = '0;
                max_d = '0;
                state_d = num_samples == '0 ? DONE : RUN;
            end
            RUN: if (accept && cnt_q == target_q - 1'b1) state_d = DRAIN;
            DRAIN: state_d = DONE;
            default: ;
        endcase
        ready_d = state_d == RUN;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            target_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
            diff_q <= '0;
            mis_q <= 1'b0;
            v1_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            target_q <= target_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            sum_q <= sum_d;
            max_q <= max_d;
            diff_q <= diff_d;
            mis_q <= mis_d;
            v1_q <= v1_d;
            ready_q <= ready_d;
        end
    end
    assign in_ready = ready_q;
    assign busy = state_q == RUN || state_q == DRAIN;
    assign done = state_q == DONE;
    assign err_count = err_q;
    assign sum_ed = sum_q;
    assign max_ed = max_q;
endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor: table-driven and randomized checks of the error monitor against a reference model
module tb_adder_error_monitor;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [15:0] num_samples = '0;
    logic [16:0] exact_sum = '0, approx_sum = '0;
    logic in_ready, busy, done, in_ready_s, busy_s, done_s;
    logic [15:0] err_count, err_count_s;
    logic [31:0] sum_ed;
    logic [17:0] sum_ed_s;
    logic [16:0] max_ed, max_ed_s;
    int total = 0, bad = 0;
    logic [16:0] qe[$], qa[$];
    typedef struct {
        int n;
        logic [16:0] e[4];
        logic [16:0] a[4];
        longint err, sum32, sum18, mx;
    } row_t;
    row_t rows[5];
    always #5 clk = ~clk;
    adder_error_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .exact_sum(exact_sum), .approx_sum(approx_sum),
        .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
    );
    adder_error_monitor #(.ACC_W(18)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_s), .exact_sum(exact_sum), .approx_sum(approx_sum),
        .busy(busy_s), .done(done_s), .err_count(err_count_s), .sum_ed(sum_ed_s), .max_ed(max_ed_s)
    );
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic check_results(input string tag, input longint e, input longint s, input longint m);
        check({tag, " err_count"}, err_count, e);
        check({tag, " err_count acc18"}, err_count_s, e);
        check({tag, " sum_ed"}, sum_ed, s > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : s);
        check({tag, " sum_ed acc18"}, sum_ed_s, s > 64'h3FFFF ? 64'h3FFFF : s);
        check({tag, " max_ed"}, max_ed, m);
        check({tag, " max_ed acc18"}, max_ed_s, m);
        check({tag, " done held"}, {done, done_s}, 2'b11);
    endtask
    task automatic check_model(input string tag);
        longint s = 0, m = 0, e = 0, d;
        foreach (qe[i]) begin
            d = longint'(qe[i]) - longint'(qa[i]);
            if (d < 0) d = -d;
            e += (d != 0) ? 1 : 0;
            s += d;
            if (d > m) m = d;
        end
        check_results(tag, e, s, m);
    endtask
    task automatic run(input int vprob, input int sprob);
        int n = qe.size(), idx = 0, budget;
        @(negedge clk);
        start = 1'b1;
        num_samples = 16'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("zero-run done", {done, done_s}, 2'b11);
            check("zero-run busy", busy, 0);
            check("zero-run ready", {in_ready, in_ready_s}, 0);
            return;
        end
        check("start done low", done, 0);
        check("start busy", busy, 1);
        check("start cleared", longint'(err_count) + sum_ed + max_ed + sum_ed_s, 0);
        budget = 8 * n + 100;
        while (idx < n && budget > 0) begin
            check("ready in run", {in_ready, in_ready_s}, 2'b11);
            in_valid = $urandom_range(99) < vprob;
            exact_sum = in_valid ? qe[idx] : 17'($urandom);
            approx_sum = in_valid ? qa[idx] : 17'($urandom);
            start = $urandom_range(99) < sprob;
            num_samples = 16'($urandom);
            if (in_ready && in_valid) idx++;
            @(negedge clk);
            budget--;
        end
        check("accepted samples", idx, n);
        start = 1'b0;
        in_valid = 1'b1;
        exact_sum = 17'($urandom);
        approx_sum = 17'($urandom);
        check("drain ready low", {in_ready, in_ready_s}, 0);
        check("drain busy/done", {busy, done}, 2'b10);
        @(negedge clk);
        check("done after drain", {busy, done, in_ready}, 3'b010);
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    initial begin
        int n;
        logic [16:0] x;
        rows[0] = '{4, '{17'd100, 17'h1FFFF, 17'd5, 17'd7}, '{17'd100, 17'd0, 17'd9, 17'd7}, 2, 131075, 131075, 131071};
        rows[1] = '{1, '{17'd3, 17'd0, 17'd0, 17'd0}, '{17'd3, 17'd0, 17'd0, 17'd0}, 0, 0, 0, 0};
        rows[2] = '{3, '{17'd0, 17'd10, 17'h10000, 17'd0}, '{17'd1, 17'd4, 17'h0FFFF, 17'd0}, 3, 8, 8, 6};
        rows[3] = '{0, '{17'd0, 17'd0, 17'd0, 17'd0}, '{17'd0, 17'd0, 17'd0, 17'd0}, 0, 0, 0, 0};
        rows[4] = '{4, '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF}, '{17'd0, 17'd0, 17'd0, 17'd0}, 4, 524284, 262143, 131071};
        repeat (2) @(negedge clk);
        check("reset flags", {in_ready, busy, done}, 0);
        check("reset results", longint'(err_count) + sum_ed + max_ed, 0);
        rst_n = 1'b1;
        foreach (rows[r]) begin
            qe.delete();
            qa.delete();
            for (int i = 0; i < rows[r].n; i++) begin
                qe.push_back(rows[r].e[i]);
                qa.push_back(rows[r].a[i]);
            end
            run(100, 20);
            check($sformatf("row%0d err_count", r), err_count, rows[r].err);
            check($sformatf("row%0d sum_ed", r), sum_ed, rows[r].sum32);
            check($sformatf("row%0d sum_ed acc18", r), sum_ed_s, rows[r].sum18);
            check($sformatf("row%0d max_ed", r), max_ed, rows[r].mx);
            check($sformatf("row%0d done", r), done, 1);
        end
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(40, 1);
            qe.delete();
            qa.delete();
            for (int i = 0; i < n; i++) begin
                x = 17'($urandom);
                qe.push_back(x);
                case ($urandom_range(2))
                    0: qa.push_back(x);
                    1: qa.push_back(17'($urandom));
                    default: qa.push_back(x ^ 17'h1);
                endcase
            end
            run(60, 10);
            check_model($sformatf("rand%0d", r));
        end
        qe.delete();
        qa.delete();
        for (int i = 0; i < 65535; i++) begin
            x = 17'($urandom);
            qe.push_back(x);
            qa.push_back(i[0] ? x : 17'($urandom));
        end
        run(100, 0);
        check_model("max target");
        @(negedge clk);
        start = 1'b1;
        num_samples = 16'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        exact_sum = 17'd40;
        approx_sum = 17'd1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("mid-run busy", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort flags", {in_ready, busy, done, in_ready_s, busy_s, done_s}, 0);
        check("abort results", longint'(err_count) + sum_ed + max_ed + sum_ed_s + max_ed_s, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle after abort", {in_ready, busy, done}, 0);
        qe.delete();
        qa.delete();
        qe.push_back(17'd9);
        qa.push_back(17'd9);
        run(100, 0);
        check_model("after abort");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
